// File: rtl/serdes_rx_packer.sv
// serdes_rx_packer: packs PACK_FACTOR received words (first word in the LSB
// lane) into one wide word and queues it in a 2-entry output buffer.
//
// Handshake: the source has no backpressure; a word is taken on every
// cycle valid_in is high. On the output side a packed word transfers on a
// rising edge where out_valid and out_ready are both high; while out_valid
// is high and out_ready is low, out_data holds its value.
module serdes_rx_packer #(
   parameter  int DATA_WIDTH  = 8,
   parameter  int PACK_FACTOR = 4,
   localparam int OUT_W       = DATA_WIDTH * PACK_FACTOR,
   localparam int CNT_W       = $clog2(PACK_FACTOR + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic                  flush,
   output logic [OUT_W-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      fill_count,
   output logic                  overflow,
   input  logic                  overflow_clr
);

   // Partial accumulation
   logic [OUT_W-1:0] r_lanes;
   logic [CNT_W-1:0] r_fill;

   // Output buffer: head is the presented word, tail is the second entry.
   // The tail is only ever valid while the head is valid.
   logic [OUT_W-1:0] r_head;
   logic [OUT_W-1:0] r_tail;
   logic             r_head_v;
   logic             r_tail_v;
   logic             r_ovf;

   logic             w_last;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [OUT_W-1:0] w_packed;

   assign w_last = (r_fill == CNT_W'(PACK_FACTOR - 1));
   // flush beats valid_in, so a flushed word never completes a packed word
   assign w_push = valid_in & ~flush & w_last;
   assign w_pop  = r_head_v & out_ready;
   // Both entries busy and nothing leaving: the completed word is lost
   assign w_drop = w_push & ~w_pop & r_tail_v;

   // Completed word: stored lanes plus the incoming word in the top lane
   always_comb begin
      w_packed = r_lanes;
      w_packed[(PACK_FACTOR-1)*DATA_WIDTH +: DATA_WIDTH] = data_in;
   end

   // Lane accumulation and fill counter; flush discards the partial word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill  <= '0;
         r_lanes <= '0;
      end else if (flush) begin
         r_fill <= '0;
      end else if (valid_in) begin
         for (int k = 0; k < PACK_FACTOR; k++) begin
            if (r_fill == CNT_W'(k)) begin
               r_lanes[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
            end
         end
         r_fill <= w_last ? '0 : r_fill + CNT_W'(1);
      end
   end

   // Two-entry output buffer; a pop is always honoured, push lands behind it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_head_v <= 1'b0;
         r_tail_v <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b11: begin
               if (r_tail_v) begin
                  r_head <= r_tail;
                  r_tail <= w_packed;
               end else begin
                  r_head <= w_packed;
               end
            end
            2'b01: begin
               r_head   <= r_tail;
               r_head_v <= r_tail_v;
               r_tail_v <= 1'b0;
            end
            2'b10: begin
               if (!r_head_v) begin
                  r_head   <= w_packed;
                  r_head_v <= 1'b1;
               end else if (!r_tail_v) begin
                  r_tail   <= w_packed;
                  r_tail_v <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Sticky overflow; a new drop takes priority over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (overflow_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign out_data   = r_head;
   assign out_valid  = r_head_v;
   assign fill_count = r_fill;
   assign overflow   = r_ovf;

endmodule
